// File: rtl/range_scan_checker.sv
// Range-table membership checker: loads inclusive [start,end] ranges, then classifies
// queried IDs by scanning the table LANES entries per cycle with early exit on a hit.
module range_scan_checker #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LANES = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       rng_valid,
  output logic                       rng_ready,
  input  logic [WIDTH-1:0]           rng_start,
  input  logic [WIDTH-1:0]           rng_end,
  input  logic                       id_valid,
  output logic                       id_ready,
  input  logic [WIDTH-1:0]           id,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_hit,
  output logic [WIDTH-1:0]           res_id,
  output logic [CNT_W-1:0]           fresh_count,
  output logic [CNT_W-1:0]           id_count,
  output logic [$clog2(DEPTH+1)-1:0] table_count,
  output logic                       table_full,
  output logic                       busy
);

  localparam int unsigned TCW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCAN   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [TCW-1:0]   base, base_nxt;
  logic [TCW-1:0]   idx;
  logic [WIDTH-1:0] tbl_start [DEPTH];
  logic [WIDTH-1:0] tbl_end   [DEPTH];
  logic             rng_fire, id_fire, res_fire;
  logic             chunk_hit, chunk_last, scan_done;

  assign table_full = (table_count == TCW'(DEPTH));
  assign busy       = (state != S_IDLE);
  assign rng_ready  = (state == S_IDLE) && !table_full && !clear;
  assign id_ready   = (state == S_IDLE) && !clear && !rng_valid;
  assign rng_fire   = rng_valid && rng_ready;
  assign id_fire    = id_valid && id_ready;
  assign res_fire   = res_valid && res_ready && !clear;
  assign scan_done  = (state == S_SCAN) && (chunk_hit || chunk_last);

  // Compare the current chunk; lanes past table_count are masked off.
  always_comb begin
    chunk_hit = 1'b0;
    idx       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx = base + TCW'(l);
      if ((idx < table_count) &&
          (tbl_start[idx[IW-1:0]] <= res_id) && (res_id <= tbl_end[idx[IW-1:0]]))
        chunk_hit = 1'b1;
    end
    chunk_last = ((base + TCW'(LANES)) >= table_count);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    case (state)
      S_IDLE: begin
        if (id_fire) begin
          base_nxt  = '0;
          state_nxt = (table_count != '0) ? S_SCAN : S_RESULT;
        end
      end
      S_SCAN: begin
        if (chunk_hit || chunk_last) state_nxt = S_RESULT;
        else                         base_nxt  = base + TCW'(LANES);
      end
      S_RESULT: begin
        if (res_fire) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      base        <= '0;
      table_count <= '0;
      fresh_count <= '0;
      id_count    <= '0;
      res_valid   <= 1'b0;
      res_hit     <= 1'b0;
      res_id      <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      base        <= '0;
      table_count <= '0;
      fresh_count <= '0;
      id_count    <= '0;
      res_valid   <= 1'b0;
    end else begin
      state <= state_nxt;
      base  <= base_nxt;
      if (rng_fire) table_count <= table_count + TCW'(1);
      if (id_fire) begin
        res_id    <= id;
        res_hit   <= 1'b0;
        res_valid <= (table_count == '0);
      end
      if (scan_done) begin
        res_valid <= 1'b1;
        res_hit   <= chunk_hit;
      end
      // Counters saturate rather than wrap
      if (res_fire) begin
        res_valid <= 1'b0;
        if (id_count != '1) id_count <= id_count + CNT_W'(1);
        if (res_hit && (fresh_count != '1)) fresh_count <= fresh_count + CNT_W'(1);
      end
    end
  end

  // Table storage carries no reset; entries at or beyond table_count are ignored.
  always_ff @(posedge clock) begin
    if (rng_fire) begin
      tbl_start[table_count[IW-1:0]] <= rng_start;
      tbl_end[table_count[IW-1:0]]   <= rng_end;
    end
  end

endmodule

// File: tb/tb_range_scan_checker.sv
// Directed and randomized checks of range_scan_checker against a queue-based
// model of the range table, result latency and saturating counters.
module tb_range_scan_checker;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LANES = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TCW   = $clog2(DEPTH + 1);
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             rng_valid = 1'b0;
  logic             rng_ready;
  logic [WIDTH-1:0] rng_start = '0;
  logic [WIDTH-1:0] rng_end = '0;
  logic             id_valid = 1'b0;
  logic             id_ready;
  logic [WIDTH-1:0] id = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             res_hit;
  logic [WIDTH-1:0] res_id;
  logic [CNT_W-1:0] fresh_count;
  logic [CNT_W-1:0] id_count;
  logic [TCW-1:0]   table_count;
  logic             table_full;
  logic             busy;

  range_scan_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_start(rng_start), .rng_end(rng_end),
    .id_valid(id_valid), .id_ready(id_ready), .id(id),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_id(res_id),
    .fresh_count(fresh_count), .id_count(id_count), .table_count(table_count),
    .table_full(table_full), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] ms[$];
  logic [63:0] me[$];
  int          m_fresh = 0;
  int          m_idc   = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Reference: first matching entry decides how many chunks get scanned.
  function automatic void model_q(input logic [63:0] v, output logic hit, output int k);
    int n;
    n   = ms.size();
    hit = 1'b0;
    k   = (n + LANES - 1) / LANES;
    for (int i = 0; i < n; i++) begin
      if (ms[i] <= v && v <= me[i]) begin
        hit = 1'b1;
        k   = i / LANES + 1;
        break;
      end
    end
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_clear();
    ms.delete();
    me.delete();
    m_fresh = 0;
    m_idc   = 0;
  endtask

  task automatic load_range(input logic [63:0] s, input logic [63:0] e);
    int guard;
    @(negedge clock);
    rng_start = s;
    rng_end   = e;
    rng_valid = 1'b1;
    #1;
    guard = 0;
    while (!rng_ready && guard < 50) begin
      @(negedge clock); #1; guard++;
    end
    if (!rng_ready) chk("rng_ready_timeout", {63'd0, rng_ready}, 64'd1);
    @(posedge clock); #1;
    rng_valid = 1'b0;
    ms.push_back(s);
    me.push_back(e);
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    model_clear();
  endtask

  // Issue one query; checks latency, hit, id and counters; hold>0 stalls res_ready.
  task automatic query(input logic [63:0] v, input int hold, input string tag,
                       output int lat, output logic hit);
    logic eh;
    int   ek, guard;
    model_q(v, eh, ek);
    @(negedge clock);
    res_ready = (hold == 0);
    id        = v;
    id_valid  = 1'b1;
    #1;
    guard = 0;
    while (!id_ready && guard < 50) begin
      @(negedge clock); #1; guard++;
    end
    chk({tag, " id_ready"}, {63'd0, id_ready}, 64'd1);
    @(posedge clock); #1;
    id_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 300) begin
      @(posedge clock); #1; lat++;
    end
    hit = res_hit;
    chk({tag, " latency"}, 64'(lat), 64'(ek + 1));
    chk({tag, " hit"}, {63'd0, res_hit}, {63'd0, eh});
    chk({tag, " res_id"}, res_id, v);
    for (int c = 0; c < hold; c++) begin
      id_valid = 1'b1;
      @(posedge clock); #1;
      chk({tag, " hold valid"}, {63'd0, res_valid}, 64'd1);
      chk({tag, " hold hit"}, {63'd0, res_hit}, {63'd0, eh});
      chk({tag, " hold id"}, res_id, v);
      chk({tag, " hold id_ready"}, {63'd0, id_ready}, 64'd0);
      chk({tag, " hold id_count"}, 64'(id_count), 64'(m_idc));
      chk({tag, " hold fresh"}, 64'(fresh_count), 64'(m_fresh));
    end
    if (hold > 0) begin
      @(negedge clock);
      id_valid  = 1'b0;
      res_ready = 1'b1;
    end
    @(posedge clock); #1;
    m_idc = sat_inc(m_idc);
    if (eh) m_fresh = sat_inc(m_fresh);
    chk({tag, " res_valid drop"}, {63'd0, res_valid}, 64'd0);
    chk({tag, " id_count"}, 64'(id_count), 64'(m_idc));
    chk({tag, " fresh_count"}, 64'(fresh_count), 64'(m_fresh));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " res_valid"}, {63'd0, res_valid}, 64'd0);
    chk({tag, " res_hit"}, {63'd0, res_hit}, 64'd0);
    chk({tag, " res_id"}, res_id, 64'd0);
    chk({tag, " table_count"}, 64'(table_count), 64'd0);
    chk({tag, " fresh_count"}, 64'(fresh_count), 64'd0);
    chk({tag, " id_count"}, 64'(id_count), 64'd0);
    chk({tag, " busy"}, {63'd0, busy}, 64'd0);
    chk({tag, " table_full"}, {63'd0, table_full}, 64'd0);
  endtask

  initial begin
    int          lat;
    logic        hit;
    logic [63:0] s, e, q;
    logic [63:0] ids  [6];
    logic        hits [6];

    // Reset state
    #2 reset = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;

    // Default directed table
    load_range(64'd3, 64'd5);
    load_range(64'd10, 64'd14);
    load_range(64'd16, 64'd20);
    load_range(64'd12, 64'd18);
    chk("basic table_count", 64'(table_count), 64'd4);
    ids  = '{64'd1, 64'd5, 64'd8, 64'd11, 64'd17, 64'd32};
    hits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      query(ids[i], 0, "basic", lat, hit);
      chk("basic hit const", {63'd0, hit}, {63'd0, hits[i]});
    end
    chk("basic fresh total", 64'(fresh_count), 64'd3);
    chk("basic id total", 64'(id_count), 64'd6);

    // Match in third chunk, and a miss over the same 17 entries
    do_clear();
    for (int i = 0; i < 16; i++) load_range(64'(1000 + i), 64'(1000 + i));
    load_range(64'd100, 64'd100);
    query(64'd100, 0, "chunk3 hit", lat, hit);
    chk("chunk3 hit lat", 64'(lat), 64'd4);
    chk("chunk3 hit val", {63'd0, hit}, 64'd1);
    query(64'd99, 0, "chunk3 miss", lat, hit);
    chk("chunk3 miss lat", 64'(lat), 64'd4);
    chk("chunk3 miss val", {63'd0, hit}, 64'd0);

    // Empty table, then fill to capacity
    do_clear();
    query(64'd7, 0, "empty", lat, hit);
    chk("empty lat", 64'(lat), 64'd1);
    chk("empty hit", {63'd0, hit}, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      s = 64'($urandom_range(0, 4000));
      e = ($urandom_range(0, 7) == 0) ? s - 64'd1 : s + 64'($urandom_range(0, 8));
      load_range(s, e);
    end
    @(negedge clock);
    rng_valid = 1'b1;
    #1;
    chk("full rng_ready", {63'd0, rng_ready}, 64'd0);
    chk("full table_full", {63'd0, table_full}, 64'd1);
    chk("full table_count", 64'(table_count), 64'(DEPTH));
    @(posedge clock); #1;
    rng_valid = 1'b0;
    chk("full no overflow", 64'(table_count), 64'(DEPTH));
    for (int i = 0; i < 20; i++) query(64'($urandom_range(0, 4100)), 0, "full rand", lat, hit);

    // Stalled result
    query(ms[130], 5, "hold", lat, hit);

    // Clear in the middle of a long miss scan
    @(negedge clock);
    id = 64'hFFFF_FFFF_FFFF;
    id_valid = 1'b1;
    @(posedge clock); #1;
    id_valid = 1'b0;
    @(posedge clock); #1;
    chk("scan busy", {63'd0, busy}, 64'd1);
    do_clear();
    chk("clear busy", {63'd0, busy}, 64'd0);
    chk("clear table_count", 64'(table_count), 64'd0);
    chk("clear id_count", 64'(id_count), 64'd0);
    chk("clear fresh", 64'(fresh_count), 64'd0);
    chk("clear res_valid", {63'd0, res_valid}, 64'd0);

    // Async reset while a result waits
    load_range(64'd5, 64'd5);
    @(negedge clock);
    res_ready = 1'b0;
    id = 64'd5;
    id_valid = 1'b1;
    @(posedge clock); #1;
    id_valid = 1'b0;
    for (int i = 0; i < 10 && !res_valid; i++) begin
      @(posedge clock); #1;
    end
    chk("pre-reset res_valid", {63'd0, res_valid}, 64'd1);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async reset");
    @(negedge clock);
    reset = 1'b1;
    res_ready = 1'b1;
    model_clear();

    // Full-span and inverted ranges
    load_range(64'd0, '1);
    query(64'd0, 0, "span zero", lat, hit);
    chk("span zero hit", {63'd0, hit}, 64'd1);
    query('1, 0, "span ones", lat, hit);
    chk("span ones hit", {63'd0, hit}, 64'd1);
    do_clear();
    load_range(64'd9, 64'd4);
    for (int i = 0; i < 3; i++) begin
      q = (i == 0) ? 64'd4 : (i == 1) ? 64'd9 : 64'd6;
      query(q, 0, "inverted", lat, hit);
      chk("inverted hit", {63'd0, hit}, 64'd0);
    end

    // Counter saturation
    do_clear();
    load_range(64'd0, '1);
    for (int i = 0; i < 20; i++) query(64'($urandom), 0, "sat", lat, hit);
    chk("sat fresh", 64'(fresh_count), 64'(SAT));
    chk("sat id", 64'(id_count), 64'(SAT));

    // Random tables of assorted sizes around chunk boundaries
    for (int r = 0; r < 6; r++) begin
      int n;
      do_clear();
      n = (r < 3) ? 8 * r + 8 + r : $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        s = 64'($urandom_range(0, 255));
        e = ($urandom_range(0, 7) == 0) ? s - 64'd1 : s + 64'($urandom_range(0, 6));
        load_range(s, e);
      end
      chk("rand table_count", 64'(table_count), 64'(n));
      for (int j = 0; j < 20; j++) query(64'($urandom_range(0, 270)), 0, "rand", lat, hit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
